mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `Memory` datapath between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the core and the `mem` wrapper. It accepts one request at a time over valid/ready handshakes and drives the memory strobe for exactly one cycle per transaction. It returns a registered response to the granted requester and holds it until accepted.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arb_grant.sv | 45 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM states, requester ids and counter width shared by the
// memory arbiter and its grant logic.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_LS = 1'b1;

   localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks the winner between IFU and LSU requests.
// Build option MEM_ARB_RR_EN: round-robin on ties, otherwise fixed LSU priority.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic if_valid,
   input  logic ls_valid,
   input  logic take,      // a request handshake completes this cycle
   output logic gnt_if,
   output logic gnt_ls
);

   logic winner;

`ifdef MEM_ARB_RR_EN
   logic last_q;

   // Remember who won the most recent handshake; reset so the LSU wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)     last_q <= REQ_IF;
      else if (take) last_q <= winner;
   end

   // A tie goes to whichever requester was not granted last.
   always_comb begin
      winner = REQ_IF;
      if (if_valid && ls_valid) winner = (last_q == REQ_IF) ? REQ_LS : REQ_IF;
      else if (ls_valid)        winner = REQ_LS;
   end
`else
   logic unused_seq;
   assign unused_seq = ^{clock, reset, take};

   // Fixed priority: the LSU always beats the IFU.
   always_comb begin
      winner = ls_valid ? REQ_LS : REQ_IF;
   end
`endif

   assign gnt_if = if_valid && (winner == REQ_IF);
   assign gnt_ls = ls_valid && (winner == REQ_LS);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between IFU and LSU, one
// transaction in flight, memory strobe LAT cycles after acceptance.
// Build option MEM_ARB_RR_EN selects round-robin arbitration on ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_resp_valid,
   input  logic                if_resp_ready,
   output logic [DATA_W-1:0]   if_resp_rdata,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic                ls_req_wr,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_wstrb,
   output logic                ls_resp_valid,
   input  logic                ls_resp_ready,
   output logic [DATA_W-1:0]   ls_resp_rdata,
   output logic                mem_en,
   output logic                mem_wr,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   // WAIT covers LAT-1 cycles, so the counter starts at LAT-2 and exits at 0.
   localparam logic [LAT_W-1:0] CNT_INIT = (LAT > 1) ? LAT_W'(LAT - 2) : '0;

   typedef struct packed {
      logic              owner;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   state_t            state_q, state_d;
   logic [LAT_W-1:0]  cnt_q;
   req_t              req_q;
   logic [DATA_W-1:0] resp_q;
   logic              gnt_if, gnt_ls, idle, take_if, take_ls, take, resp_take;

   mem_arb_grant u_grant (
      .clock    (clock),
      .reset    (reset),
      .if_valid (if_req_valid),
      .ls_valid (ls_req_valid),
      .take     (take),
      .gnt_if   (gnt_if),
      .gnt_ls   (gnt_ls)
   );

   // Ready only in IDLE and never while reset is held.
   assign idle         = (state_q == IDLE) && !reset;
   assign if_req_ready = idle && gnt_if;
   assign ls_req_ready = idle && gnt_ls;
   assign take_if      = if_req_valid && if_req_ready;
   assign take_ls      = ls_req_valid && ls_req_ready;
   assign take         = take_if || take_ls;
   assign resp_take    = (req_q.owner == REQ_LS) ? ls_resp_ready : if_resp_ready;

   assign mem_addr      = req_q.addr;
   assign mem_wdata     = req_q.wdata;
   assign if_resp_rdata = resp_q;
   assign ls_resp_rdata = resp_q;

   // Next state plus strobe/response-valid decode.
   always_comb begin
      state_d       = state_q;
      mem_en        = 1'b0;
      mem_wr        = 1'b0;
      mem_wstrb     = '0;
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
      case (state_q)
         IDLE:   if (take) state_d = (LAT > 1) ? WAIT : ACCESS;
         WAIT:   if (cnt_q == '0) state_d = ACCESS;
         ACCESS: begin
            mem_en    = 1'b1;
            mem_wr    = req_q.wr;
            mem_wstrb = req_q.wstrb;
            state_d   = RESP;
         end
         RESP: begin
            if_resp_valid = (req_q.owner == REQ_IF);
            ls_resp_valid = (req_q.owner == REQ_LS);
            if (resp_take) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any in-flight transaction immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Latency counter: loaded at acceptance, counts down through WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                cnt_q <= '0;
      else if (take)                            cnt_q <= CNT_INIT;
      else if (state_q == WAIT && cnt_q != '0)  cnt_q <= cnt_q - LAT_W'(1);
   end

   // Capture the accepted request; fetches are always reads with no strobes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_q <= '0;
      end else if (take) begin
         req_q.owner <= take_ls ? REQ_LS : REQ_IF;
         req_q.wr    <= take_ls && ls_req_wr;
         req_q.addr  <= take_ls ? ls_req_addr : if_req_addr;
         req_q.wdata <= take_ls ? ls_req_wdata : '0;
         req_q.wstrb <= take_ls ? ls_req_wstrb : '0;
      end
   end

   // Response register: read data sampled in ACCESS, zero for store acks.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  resp_q <= '0;
      else if (state_q == ACCESS) resp_q <= req_q.wr ? '0 : mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks on two arbiters (LAT=1 and LAT=4), each
// attached to a small byte-enabled memory model.
module tb_mem_arbiter;

   logic clock, reset;
   logic [1:0]       if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
   logic [1:0][31:0] if_req_addr, if_resp_rdata;
   logic [1:0]       ls_req_valid, ls_req_ready, ls_req_wr, ls_resp_valid, ls_resp_ready;
   logic [1:0][31:0] ls_req_addr, ls_req_wdata, ls_resp_rdata;
   logic [1:0][3:0]  ls_req_wstrb, mem_wstrb;
   logic [1:0]       mem_en, mem_wr;
   logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      logic [31:0] mem_q [0:4095];
      int en_cnt;

      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(g == 0 ? 1 : 4)) u_dut (
         .clock         (clock),
         .reset         (reset),
         .if_req_valid  (if_req_valid[g]),
         .if_req_ready  (if_req_ready[g]),
         .if_req_addr   (if_req_addr[g]),
         .if_resp_valid (if_resp_valid[g]),
         .if_resp_ready (if_resp_ready[g]),
         .if_resp_rdata (if_resp_rdata[g]),
         .ls_req_valid  (ls_req_valid[g]),
         .ls_req_ready  (ls_req_ready[g]),
         .ls_req_wr     (ls_req_wr[g]),
         .ls_req_addr   (ls_req_addr[g]),
         .ls_req_wdata  (ls_req_wdata[g]),
         .ls_req_wstrb  (ls_req_wstrb[g]),
         .ls_resp_valid (ls_resp_valid[g]),
         .ls_resp_ready (ls_resp_ready[g]),
         .ls_resp_rdata (ls_resp_rdata[g]),
         .mem_en        (mem_en[g]),
         .mem_wr        (mem_wr[g]),
         .mem_addr      (mem_addr[g]),
         .mem_wdata     (mem_wdata[g]),
         .mem_wstrb     (mem_wstrb[g]),
         .mem_rdata     (mem_rdata[g])
      );

      assign mem_rdata[g] = mem_q[mem_addr[g][13:2]];

      initial begin
         for (int i = 0; i < 4096; i++) mem_q[i] = '0;
         mem_q[0]      = 32'h0000_0413;   // 0x80000000
         mem_q[12'h400] = 32'h1122_3344;  // 0x80001000
         en_cnt = 0;
      end

      always @(posedge clock) begin
         if (mem_en[g]) begin
            en_cnt <= en_cnt + 1;
            if (mem_wr[g])
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[g][b]) mem_q[mem_addr[g][13:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_ls, seen, bad;
      reset = 1'b1;
      if_req_valid = '0; if_req_addr = '0; if_resp_ready = '0;
      ls_req_valid = '0; ls_req_wr = '0; ls_req_addr = '0; ls_req_wdata = '0;
      ls_req_wstrb = '0; ls_resp_ready = '0;

      // ---- reset state (request offered while reset is held) ----
      step(); step();
      if_req_valid[0] = 1'b1; ls_req_valid[0] = 1'b1;
      #1;
      check("rst_if_ready",   if_req_ready[0], 0);
      check("rst_ls_ready",   ls_req_ready[0], 0);
      check("rst_mem_en",     mem_en[0], 0);
      check("rst_mem_wr",     mem_wr[0], 0);
      check("rst_mem_wstrb",  mem_wstrb[0], 0);
      check("rst_resp_valid", {if_resp_valid[0], ls_resp_valid[0]}, 0);
      check("rst_resp_data",  ls_resp_rdata[0], 0);
      if_req_valid[0] = 1'b0; ls_req_valid[0] = 1'b0;
      step();
      reset = 1'b0;
      step();

      // ---- LAT=1 IFU fetch ----
      if_req_valid[0] = 1'b1; if_req_addr[0] = 32'h8000_0000; if_resp_ready[0] = 1'b1;
      #1;
      check("if_ready_idle", if_req_ready[0], 1);
      check("ls_ready_idle", ls_req_ready[0], 0);
      step();
      check("if_mem_en_c1",  mem_en[0], 1);
      check("if_mem_addr",   mem_addr[0], 32'h8000_0000);
      check("if_mem_wr",     mem_wr[0], 0);
      check("if_busy_ready", if_req_ready[0], 0);
      if_req_valid[0] = 1'b0;
      step();
      check("if_resp_valid_c2", if_resp_valid[0], 1);
      check("if_resp_data",     if_resp_rdata[0], 32'h0000_0413);
      check("if_ls_resp_quiet", ls_resp_valid[0], 0);
      check("if_mem_en_c2",     mem_en[0], 0);
      step();
      check("if_resp_done",  if_resp_valid[0], 0);
      check("if_en_count",   gen_dut[0].en_cnt, 1);

      // ---- LSU partial write then read-back ----
      ls_req_valid[0] = 1'b1; ls_req_wr[0] = 1'b1; ls_req_addr[0] = 32'h8000_1000;
      ls_req_wdata[0] = 32'hDEAD_BEEF; ls_req_wstrb[0] = 4'b0011; ls_resp_ready[0] = 1'b1;
      #1;
      check("wr_ls_ready", ls_req_ready[0], 1);
      step();
      ls_req_valid[0] = 1'b0;
      check("wr_mem_en",    mem_en[0], 1);
      check("wr_mem_wr",    mem_wr[0], 1);
      check("wr_mem_wstrb", mem_wstrb[0], 4'b0011);
      check("wr_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      step();
      check("wr_ack_valid", ls_resp_valid[0], 1);
      check("wr_ack_data",  ls_resp_rdata[0], 0);
      check("wr_mem_en_off", mem_en[0], 0);
      step();
      ls_req_valid[0] = 1'b1; ls_req_wr[0] = 1'b0;
      step();
      ls_req_valid[0] = 1'b0;
      check("rd_mem_wr", mem_wr[0], 0);
      step();
      check("rd_valid", ls_resp_valid[0], 1);
      check("rd_data",  ls_resp_rdata[0], 32'h1122_BEEF);
      step();
      check("wr_rd_en_count", gen_dut[0].en_cnt, 3);

      // ---- arbitration with both requesters always valid ----
      reset = 1'b1;
      step();
      reset = 1'b0;
      if_req_valid[0] = 1'b1; if_req_addr[0] = 32'h8000_0000;
      ls_req_valid[0] = 1'b1; ls_req_wr[0] = 1'b0; ls_req_addr[0] = 32'h8000_0000;
      for (int t = 0; t < 8; t++) begin
`ifdef MEM_ARB_RR_EN
         exp_ls = (t % 2 == 0);
`else
         exp_ls = 1'b1;
`endif
         #1;
         check("arb_ls_ready", ls_req_ready[0], exp_ls);
         check("arb_if_ready", if_req_ready[0], !exp_ls);
         step();
         step();
         check("arb_resp_owner", {ls_resp_valid[0], if_resp_valid[0]}, {exp_ls, !exp_ls});
         step();
      end
      if_req_valid[0] = 1'b0; ls_req_valid[0] = 1'b0;

      // ---- LAT=4 with LSU response back-pressure ----
      ls_req_valid[1] = 1'b1; ls_req_wr[1] = 1'b0; ls_req_addr[1] = 32'h8000_0000;
      if_req_valid[1] = 1'b1; if_req_addr[1] = 32'h8000_0000; if_resp_ready[1] = 1'b1;
      #1;
      check("l4_ls_ready", ls_req_ready[1], 1);
      check("l4_if_ready", if_req_ready[1], 0);
      step();
      ls_req_valid[1] = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         check("l4_mem_en",     mem_en[1], (c == 4));
         check("l4_resp_valid", ls_resp_valid[1], (c >= 5));
         check("l4_no_ready",   if_req_ready[1], 0);
         if (c >= 5) check("l4_resp_hold", ls_resp_rdata[1], 32'h0000_0413);
         if (c == 9) ls_resp_ready[1] = 1'b1;
         if (c < 9) step();
      end
      step();
      check("l4_resp_done", ls_resp_valid[1], 0);
      #1;
      check("l4_if_granted", if_req_ready[1], 1);
      step();
      if_req_valid[1] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (if_resp_valid[1]) seen = 1'b1;
         else step();
      end
      check("l4_if_resp_seen", seen, 1);
      check("l4_if_resp_data", if_resp_rdata[1], 32'h0000_0413);
      step();
      check("l4_en_count", gen_dut[1].en_cnt, 2);

      // ---- reset during WAIT of an LSU write ----
      ls_req_valid[1] = 1'b1; ls_req_wr[1] = 1'b1; ls_req_addr[1] = 32'h8000_1000;
      ls_req_wdata[1] = 32'hCAFE_F00D; ls_req_wstrb[1] = 4'b1111;
      #1;
      check("rw_ls_ready", ls_req_ready[1], 1);
      step();
      ls_req_valid[1] = 1'b0;
      reset = 1'b1;
      #1;
      check("rw_mem_en_in_rst", mem_en[1], 0);
      step();
      reset = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (mem_en[1] || ls_resp_valid[1]) bad = 1'b1;
         step();
      end
      check("rw_no_activity", bad, 0);
      check("rw_en_count",    gen_dut[1].en_cnt, 2);
      check("rw_mem_intact",  gen_dut[1].mem_q[12'h400], 32'h1122_3344);
      ls_req_valid[1] = 1'b1; ls_req_wr[1] = 1'b0;
      #1;
      check("rw_next_ready", ls_req_ready[1], 1);
      step();
      ls_req_valid[1] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (ls_resp_valid[1]) seen = 1'b1;
         else step();
      end
      check("rw_next_seen", seen, 1);
      check("rw_next_data", ls_resp_rdata[1], 32'h1122_3344);
      step();
      check("rw_next_en_count", gen_dut[1].en_cnt, 3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
